// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device: request-to-send (clock held low),
// start bit, 8 data bits LSB first, odd parity, stop bit, then samples the
// device acknowledge. Both bus lines are driven through open-drain pull-low
// enables. A watchdog aborts the frame if the device stops clocking.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = 12_000,
  parameter int TIMEOUT_CYCLES = 1_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] cmd_byte,
  input  logic       ps2_clock_i,
  input  logic       ps2_data_i,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;

  // The clock frequency only documents the timing basis of the cycle counts;
  // a non-positive value leaves the design without a meaningful time base.
  if (CLK_FREQ_HZ <= 0) begin : g_no_time_base
  end

  // Synchronizer and edge-detect flops. Idle bus level is high.
  logic clk_s1_q, clk_s1_d;
  logic clk_s2_q, clk_s2_d;
  logic clk_prev_q, clk_prev_d;
  logic dat_s1_q, dat_s1_d;
  logic dat_s2_q, dat_s2_d;

  // Protocol state.
  logic [2:0]    state_q, state_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    idx_q, idx_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          nack_q, nack_d;

  // Registered outputs.
  logic clock_oe_q, clock_oe_d;
  logic data_oe_q, data_oe_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;

  logic clk_fe;
  logic counting;

  assign clk_fe   = clk_prev_q & ~clk_s2_q;
  assign counting = (state_q == S_SHIFT) || (state_q == S_ACK) || (state_q == S_WAIT);

  // Two-stage synchronizers plus one extra clock stage for falling-edge detection.
  always_comb begin
    clk_s1_d   = ps2_clock_i;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_data_i;
    dat_s2_d   = dat_s1_q;
  end

  // Next-state logic for the frame sequencer, counters and outputs.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    inh_d      = inh_q;
    wd_d       = wd_q;
    nack_d     = nack_q;
    clock_oe_d = clock_oe_q;
    data_oe_d  = data_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    // Watchdog: restarts on every device clock falling edge, saturates at its limit.
    if (counting) begin
      if (clk_fe) begin
        wd_d = '0;
      end else if (wd_q != WD_MAX) begin
        wd_d = wd_q + WW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        busy_d     = 1'b0;
        if (send) begin
          frame_d    = {1'b1, ~^cmd_byte, cmd_byte};
          inh_d      = '0;
          idx_d      = '0;
          wd_d       = '0;
          nack_d     = 1'b0;
          busy_d     = 1'b1;
          clock_oe_d = 1'b1;
          state_d    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_START;
        end else begin
          inh_d = inh_q + IW'(1);
        end
      end
      S_START: begin
        // Start bit stays on data; releasing clock hands control to the device.
        clock_oe_d = 1'b0;
        idx_d      = '0;
        wd_d       = '0;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        if (clk_fe) begin
          data_oe_d = ~frame_q[idx_q];
          if (idx_q == 4'd9) begin
            state_d = S_ACK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (clk_fe) begin
          nack_d  = dat_s2_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (clk_s2_q && dat_s2_q) begin
          done_d  = ~nack_q;
          error_d = nack_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    // Watchdog expiry overrides everything: release the bus and report failure.
    if (counting && !clk_fe && (wd_q == WD_LAST)) begin
      clock_oe_d = 1'b0;
      data_oe_d  = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b1;
      state_d    = S_IDLE;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      state_q    <= S_IDLE;
      frame_q    <= '0;
      idx_q      <= '0;
      inh_q      <= '0;
      wd_q       <= '0;
      nack_q     <= 1'b0;
      clock_oe_q <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      state_q    <= state_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      inh_q      <= inh_d;
      wd_q       <= wd_d;
      nack_q     <= nack_d;
      clock_oe_q <= clock_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign ps2_clock_oe = clock_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign rx_inhibit   = busy_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: open-drain bus model, scripted PS/2 device and a
// scoreboard of expected frames/outcomes pushed at send time.
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TO   = 1000;
  localparam int HALF = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic send = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk_line, ps2_dat_line;
  logic clock_oe, data_oe, busy, done, error, rx_inhibit;

  always #5 clk = ~clk;

  assign ps2_clk_line = ~(clock_oe | dev_clk_low);
  assign ps2_dat_line = ~(data_oe | dev_dat_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ   (100_000_000),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .send        (send),
    .cmd_byte    (cmd_byte),
    .ps2_clock_i (ps2_clk_line),
    .ps2_data_i  (ps2_dat_line),
    .ps2_clock_oe(clock_oe),
    .ps2_data_oe (data_oe),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .rx_inhibit  (rx_inhibit)
  );

  typedef struct {
    logic [9:0] frame;
    logic       ack;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor sampled on the falling clock edge.
  int done_cnt = 0, err_cnt = 0, busy_rise = 0, bad_pulse = 0, lingering = 0;
  logic busy_prev = 1'b0, pulse_prev = 1'b0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (busy && !busy_prev) busy_rise++;
    if ((done || error) && !busy) bad_pulse++;
    if (done && error) bad_pulse++;
    if (pulse_prev && busy) lingering++;
    if (rx_inhibit !== busy) bad_pulse++;
    busy_prev  = busy;
    pulse_prev = done || error;
  end

  function automatic logic [9:0] make_frame(input logic [7:0] c);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (c[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, c};
  endfunction

  // Drive a one-cycle send and record the expectation.
  task automatic start_send(input logic [7:0] c, input logic ack);
    exp_t e;
    @(negedge clk);
    send = 1'b1;
    cmd_byte = c;
    @(negedge clk);
    send = 1'b0;
    e.frame = make_frame(c);
    e.ack = ack;
    sb.push_back(e);
    check("accept_busy_clk", {busy, clock_oe, data_oe}, 3'b110);
  endtask

  // Measure inhibit and start-bit durations; optionally fire a stray send.
  task automatic inhibit_phase(input logic stray);
    int n = 0;
    int m = 0;
    while (clock_oe && !data_oe && n < INH + 20) begin
      if (stray && n == 50) begin
        send = 1'b1;
        cmd_byte = 8'h00;
      end else begin
        send = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    send = 1'b0;
    check("inhibit_len", n, INH);
    while (clock_oe && data_oe && m < 5) begin
      @(negedge clk);
      m++;
    end
    check("start_len", m, 1);
    check("shift_entry_oe", {clock_oe, data_oe}, 2'b01);
  endtask

  // Device model: generates nfalls clock pulses, reads host bits while clock low.
  task automatic dev_clock(input logic ack, input int nfalls, output logic [9:0] bits);
    bits = '0;
    repeat (5) @(negedge clk);
    check("start_bit", data_oe, 1'b1);
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 11 && ack) begin
        dev_dat_low = 1'b1;
        repeat (3) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k <= 10) bits[k-1] = ~data_oe;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] c, input logic ack, input logic stray);
    logic [9:0] bits;
    int dc0, ec0, br0, n;
    exp_t e;
    dc0 = done_cnt;
    ec0 = err_cnt;
    br0 = busy_rise;
    start_send(c, ack);
    inhibit_phase(stray);
    dev_clock(ack, 11, bits);
    n = 0;
    while (done_cnt == dc0 && err_cnt == ec0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("outcome_seen", (n < 200), 1'b1);
    repeat (30) @(negedge clk);
    e = sb.pop_front();
    check($sformatf("bits_%02h", c), bits, e.frame);
    check("done_cnt", done_cnt - dc0, e.ack ? 1 : 0);
    check("err_cnt", err_cnt - ec0, e.ack ? 0 : 1);
    check("busy_rise", busy_rise - br0, 1);
    check("idle_after", {busy, clock_oe, data_oe}, 3'b000);
    $display("[TB] frame cmd=%02h ack=%0d stray=%0d bits=%03h done=%0d err=%0d",
             c, ack, stray, bits, done_cnt - dc0, err_cnt - ec0);
  endtask

  initial begin
    int c, dc0, ec0;
    logic [9:0] bits;
    exp_t e;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {clock_oe, data_oe, busy, done, error, rx_inhibit}, 6'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset released");

    run_frame(8'hED, 1'b1, 1'b0);
    run_frame(8'hF4, 1'b1, 1'b0);
    run_frame(8'hFF, 1'b1, 1'b0);
    run_frame(8'hA5, 1'b0, 1'b0);   // no acknowledge
    run_frame(8'hED, 1'b1, 1'b1);   // stray send of 0x00 while busy

    // Device never clocks: watchdog expiry.
    dc0 = done_cnt;
    ec0 = err_cnt;
    start_send(8'h3C, 1'b0);
    inhibit_phase(1'b0);
    c = 0;
    while (!error && c < TO + 50) begin
      @(negedge clk);
      c++;
    end
    check("timeout_cycles", c, TO);
    check("timeout_oe", {clock_oe, data_oe}, 2'b00);
    repeat (30) @(negedge clk);
    e = sb.pop_front();
    check("timeout_done", done_cnt - dc0, e.ack ? 1 : 0);
    check("timeout_err", err_cnt - ec0, 1);
    $display("[TB] timeout cmd=3c cycles=%0d", c);

    // Reset after the 5th falling edge.
    dc0 = done_cnt;
    ec0 = err_cnt;
    start_send(8'hF4, 1'b1);
    inhibit_phase(1'b0);
    dev_clock(1'b1, 5, bits);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {clock_oe, data_oe, busy, done, error, rx_inhibit}, 6'b0);
    reset = 1'b0;
    void'(sb.pop_front());
    repeat (30) @(negedge clk);
    check("midreset_no_pulse", (done_cnt - dc0) + (err_cnt - ec0), 0);
    $display("[TB] mid-frame reset after 5 falls");
    run_frame(8'hF4, 1'b1, 1'b0);

    check("pulse_while_busy", bad_pulse, 0);
    check("busy_after_pulse", lingering, 0);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter: sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It drives the shared PS/2 clock and data lines through open-drain pull-low enables. It implements the request-to-send, bit shifting, odd parity, stop bit and device-acknowledge sequence. It sits beside the PS/2 receive decoder on the same two lines and asserts `rx_inhibit` while a frame is in flight so the decoder ignores bus activity.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: frequency of `clock`.
- `INHIBIT_CYCLES`, 12_000: cycles the clock line is held low before the start bit (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, 1_500_000: watchdog limit between consecutive device clock falling edges (15 ms).

- `clock`: in, 1. System clock; 100 MHz in the top level.
- `reset`: in, 1. Synchronous, active-high.
- `send`: in, 1. Request to transmit `cmd_byte`; sampled only in IDLE.
- `cmd_byte`: in, 8. Byte to send; latched on the accepting cycle.
- `ps2_clock_i`: in, 1. Raw PS/2 clock pin level (asynchronous).
- `ps2_data_i`: in, 1. Raw PS/2 data pin level (asynchronous).
- `ps2_clock_oe`: out, 1. 1 = pull the clock line low; 0 = release it.
- `ps2_data_oe`: out, 1. 1 = pull the data line low; 0 = release it.
- `busy`: out, 1. High from acceptance until the completion cycle, inclusive.
- `done`: out, 1. One-cycle pulse: frame sent and acknowledged.
- `error`: out, 1. One-cycle pulse: no acknowledge, or watchdog expired.
- `rx_inhibit`: out, 1. Equal to `busy`; wired to the receive decoder.

## Operation
- Both pin inputs pass through a 2-flop synchronizer. A falling edge (`fe`) is synced-previous = 1 and synced-current = 0. All protocol decisions use the synchronized values only.
- Frame: shift register `{stop=1, parity, cmd[7:0]}`, where parity is odd: parity = ~^cmd.
- States:
  - IDLE: all outputs 0. When `send`=1, latch `cmd_byte`, clear counters, go to INHIBIT.
  - INHIBIT: `ps2_clock_oe`=1. Count INHIBIT_CYCLES, then go to START.
  - START: `ps2_clock_oe`=1 and `ps2_data_oe`=1 (start bit 0) for exactly 1 cycle, then go to SHIFT with `ps2_clock_oe`=0 and bit index 0.
  - SHIFT: on each `fe`, put frame bit[index] on the bus (`ps2_data_oe` = ~bit) and increment index. The 10th `fe` drives stop = 1, which releases data. The next `fe` goes to ACK.
  - ACK: on the 11th `fe`, sample synced data. 0 = acknowledge; 1 = record no-ack. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock = 1 and synced data = 1. Then pulse `done` (acknowledged) or `error` (no-ack) and return to IDLE.
- Watchdog:
  - Counts in SHIFT, ACK and WAIT_IDLE.
  - Cleared on entry to SHIFT and on every `fe`.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse `error`, return to IDLE.
- Exactly one of `done` or `error` fires per accepted `send`; never both.
- `send` while busy is ignored. It is not queued.

## Timing
- Reset (synchronous): state IDLE. `ps2_clock_oe`, `ps2_data_oe`, `busy`, `done`, `error` and `rx_inhibit` are all 0 on the cycle after `reset` is sampled high.
- Reset mid-frame: both lines are released on the next cycle, and neither `done` nor `error` is pulsed.
- Acceptance at cycle N: `busy` and `ps2_clock_oe` are 1 at N+1. `ps2_data_oe` rises at N+1+INHIBIT_CYCLES. `ps2_clock_oe` falls one cycle later.
- Data update latency: the bus bit changes 3 cycles after the raw pin falls (2 synchronizer stages plus 1 registered output). This is well inside the device's low half-period of at least 30 µs.
- `done`/`error` are asserted on the cycle WAIT_IDLE sees both lines high. `busy` is still 1 that cycle and falls at the next.
- A `send` held high continuously starts a new frame on the first IDLE cycle after completion.
- Counters: inhibit counter width = $clog2(INHIBIT_CYCLES+1); watchdog width = $clog2(TIMEOUT_CYCLES+1). Neither counter wraps; each stops at its limit.

## Test plan
- Send 0xED with a device model that acks. Data bits are driven 1,0,1,1,0,1,1,1 (LSB first), parity 1, then stop. Clock is held low for 12000 cycles before the start bit. Expect `done`=1 for exactly one cycle and `error` never high.
- Send 0xF4. Parity bit = 0. Send 0xFF. Parity bit = 1. Expect `done` on each.
- Device model leaves data high at the 11th falling edge. Expect `error` pulse after the lines go idle, and `done` never high.
- Device never clocks after the clock line is released. Expect `error` exactly TIMEOUT_CYCLES after entering SHIFT, with both `_oe` = 0.
- Assert `reset` after the 5th falling edge. Next cycle: all outputs 0. A new `send` of 0xF4 then completes with `done`.
- Pulse `send` with 0x00 while busy sending 0xED. The 0x00 is ignored: only the 0xED bits appear, with a single `done`.
